// File: rtl/linescanner_line_assembler.sv
// Line assembler: frames lval-delimited pixel runs into {sol, eol, data} entries
// and queues them in an output FIFO, with line statistics and sticky error flags.
module linescanner_line_assembler #(
  parameter int LINE_WIDTH = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        pixel_clock,
  input  logic        n_reset,
  input  logic        enable,
  input  logic        lval,
  input  logic [7:0]  pixel_data,
  output logic [7:0]  out_data,
  output logic        out_sol,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] line_count,
  output logic [11:0] last_line_length,
  output logic        err_overflow,
  output logic        err_long,
  output logic        err_short
);

  localparam int          AW = $clog2(FIFO_DEPTH);
  localparam logic [11:0] LW = 12'(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CAPTURE       = 2'd1,
    WAIT_LVAL_LOW = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          prev_lval_q, prev_lval_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic          pend_sol_q, pend_sol_d;
  logic [15:0]   line_count_q, line_count_d;
  logic [11:0]   last_len_q, last_len_d;
  logic          err_overflow_q, err_overflow_d;
  logic          err_long_q, err_long_d;
  logic          err_short_q, err_short_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [9:0]    mem_q [FIFO_DEPTH];

  logic          push_s, push_eol_s, push_ok_s, pop_s;
  logic          full_s, empty_s, line_done_s;
  logic [9:0]    push_entry_s;
  logic [9:0]    head_s;

  assign empty_s = (wptr_q == rptr_q);
  assign full_s  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_s  = mem_q[rptr_q[AW-1:0]];

  assign out_data         = head_s[7:0];
  assign out_eol          = head_s[8];
  assign out_sol          = head_s[9];
  assign out_valid        = !empty_s;
  assign line_count       = line_count_q;
  assign last_line_length = last_len_q;
  assign err_overflow     = err_overflow_q;
  assign err_long         = err_long_q;
  assign err_short        = err_short_q;

  // Next-state logic: line framing FSM, pending pixel stage and FIFO pointers.
  always_comb begin
    state_d        = state_q;
    prev_lval_d    = lval;
    cnt_d          = cnt_q;
    pend_data_d    = pend_data_q;
    pend_sol_d     = pend_sol_q;
    line_count_d   = line_count_q;
    last_len_d     = last_len_q;
    err_overflow_d = err_overflow_q;
    err_long_d     = err_long_q;
    err_short_d    = err_short_q;
    push_s         = 1'b0;
    push_eol_s     = 1'b0;
    line_done_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (lval) begin
          if (enable && !prev_lval_q) begin
            state_d     = CAPTURE;
            pend_data_d = pixel_data;
            pend_sol_d  = 1'b1;
            cnt_d       = 12'd1;
          end else begin
            state_d = WAIT_LVAL_LOW;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        push_s = 1'b1;
        if (lval && (cnt_q < LW)) begin
          pend_data_d = pixel_data;
          pend_sol_d  = 1'b0;
          cnt_d       = cnt_q + 12'd1;
        end else begin
          // Line closes: either lval fell or the line hit LINE_WIDTH and lval is still high.
          push_eol_s  = 1'b1;
          line_done_s = 1'b1;
          if (lval) begin
            err_long_d = 1'b1;
            state_d    = WAIT_LVAL_LOW;
          end else begin
            state_d = IDLE;
            if (cnt_q < LW) begin
              err_short_d = 1'b1;
            end else begin
              err_short_d = err_short_q;
            end
          end
        end
      end
      WAIT_LVAL_LOW: begin
        if (!lval) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_LVAL_LOW;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (line_done_s) begin
      line_count_d = line_count_q + 16'd1;
      last_len_d   = cnt_q;
    end else begin
      line_count_d = line_count_q;
    end

    push_entry_s = {pend_sol_q, push_eol_s, pend_data_q};
    pop_s        = !empty_s && out_ready;
    push_ok_s    = push_s && (!full_s || pop_s);

    if (push_s && !push_ok_s) begin
      err_overflow_d = 1'b1;
    end else begin
      err_overflow_d = err_overflow_q;
    end

    wptr_d = push_ok_s ? (wptr_q + (AW+1)'(1)) : wptr_q;
    rptr_d = pop_s     ? (rptr_q + (AW+1)'(1)) : rptr_q;
  end

  // State registers with synchronous active-low reset; lval history runs through reset.
  always_ff @(posedge pixel_clock) begin
    prev_lval_q <= prev_lval_d;
    if (!n_reset) begin
      state_q        <= IDLE;
      cnt_q          <= 12'd0;
      pend_data_q    <= 8'd0;
      pend_sol_q     <= 1'b0;
      line_count_q   <= 16'd0;
      last_len_q     <= 12'd0;
      err_overflow_q <= 1'b0;
      err_long_q     <= 1'b0;
      err_short_q    <= 1'b0;
      wptr_q         <= '0;
      rptr_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_data_q    <= pend_data_d;
      pend_sol_q     <= pend_sol_d;
      line_count_q   <= line_count_d;
      last_len_q     <= last_len_d;
      err_overflow_q <= err_overflow_d;
      err_long_q     <= err_long_d;
      err_short_q    <= err_short_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge pixel_clock) begin
    if (n_reset && push_ok_s) begin
      mem_q[wptr_q[AW-1:0]] <= push_entry_s;
    end
  end

endmodule
